// File: rtl/armleocpu_operand_fetch.sv
// Operand fetch stage between decode and execute: drives the register file read
// ports, tracks in-flight destinations in a scoreboard and bypasses same-cycle writeback.
module armleocpu_operand_fetch #(
    parameter int PC_W  = 32,
    parameter int UOP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [UOP_W-1:0] in_uop,
    input  logic             in_rs1_use,
    input  logic             in_rs2_use,
    input  logic [4:0]       in_rs1_addr,
    input  logic [4:0]       in_rs2_addr,
    input  logic             in_rd_write,
    input  logic [4:0]       in_rd_addr,

    output logic             rs1_read,
    output logic             rs2_read,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [31:0]      rs1_rdata,
    input  logic [31:0]      rs2_rdata,

    input  logic             wb_write,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_wdata,

    input  logic             flush,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [UOP_W-1:0] out_uop,
    output logic [31:0]      out_rs1_data,
    output logic [31:0]      out_rs2_data,
    output logic             out_rd_write,
    output logic [4:0]       out_rd_addr
);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pend_q, pend_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [UOP_W-1:0]   uop_q, uop_d;
    logic               rd_write_q, rd_write_d;
    logic [4:0]         rd_addr_q, rd_addr_d;
    logic [1:0]         zero_q, zero_d;
    logic [1:0]         byp_q, byp_d;
    logic [1:0][31:0]   byp_data_q, byp_data_d;

    logic [1:0]         src_use;
    logic [1:0][4:0]    src_addr;
    logic [1:0][31:0]   src_rdata;
    logic [1:0]         src_busy;
    logic [1:0]         src_byp;
    logic [1:0][31:0]   op_data;
    logic               raw_hazard;
    logic               waw_hazard;
    logic               accept;
    logic               out_hs;

    // A register is busy if a producer is pending or sitting in the output slot,
    // unless its writeback lands this very cycle (then the bypass covers it).
    function automatic logic reg_busy(
        input logic [4:0]  a,
        input logic [31:0] pend,
        input logic        ov,
        input logic        rdw,
        input logic [4:0]  rda,
        input logic        wbw,
        input logic [4:0]  wba
    );
        return (a != 5'd0) && (pend[a] || (ov && rdw && (rda == a))) && !(wbw && (wba == a));
    endfunction

    assign out_valid = (state_q == HELD);
    assign src_use   = {in_rs2_use, in_rs1_use};
    assign src_addr  = {in_rs2_addr, in_rs1_addr};
    assign src_rdata = {rs2_rdata, rs1_rdata};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_busy[gi] = src_use[gi] &&
                reg_busy(src_addr[gi], pend_q, out_valid, rd_write_q, rd_addr_q, wb_write, wb_addr);
            assign src_byp[gi]  = wb_write && (wb_addr == src_addr[gi]) && (src_addr[gi] != 5'd0);
            assign op_data[gi]  = zero_q[gi] ? 32'd0 : (byp_q[gi] ? byp_data_q[gi] : src_rdata[gi]);
        end
    endgenerate

    assign raw_hazard = |src_busy;
    assign waw_hazard = in_rd_write &&
        reg_busy(in_rd_addr, pend_q, out_valid, rd_write_q, rd_addr_q, wb_write, wb_addr);

    // Gating with rst_n keeps the read enables low while reset is held.
    assign in_ready = rst_n && (!out_valid || out_ready) && !raw_hazard && !waw_hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready && !flush;

    assign rs1_addr = in_rs1_addr;
    assign rs2_addr = in_rs2_addr;
    assign rs1_read = accept && in_rs1_use;
    assign rs2_read = accept && in_rs2_use;

    assign out_pc       = pc_q;
    assign out_uop      = uop_q;
    assign out_rd_write = rd_write_q;
    assign out_rd_addr  = rd_addr_q;
    assign out_rs1_data = op_data[0];
    assign out_rs2_data = op_data[1];

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pc_d       = pc_q;
        uop_d      = uop_q;
        rd_write_d = rd_write_q;
        rd_addr_d  = rd_addr_q;
        zero_d     = zero_q;
        byp_d      = byp_q;
        byp_data_d = byp_data_q;

        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = HELD;
        end else if (out_hs) begin
            state_d = EMPTY;
        end

        if (accept) begin
            pc_d       = in_pc;
            uop_d      = in_uop;
            rd_write_d = in_rd_write;
            rd_addr_d  = in_rd_addr;
            for (int i = 0; i < 2; i++) begin
                zero_d[i]     = !src_use[i] || (src_addr[i] == 5'd0);
                byp_d[i]      = src_byp[i];
                byp_data_d[i] = wb_wdata;
            end
        end

        // Clear first so a set on the same index wins.
        if (wb_write) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (out_hs && rd_write_q && (rd_addr_q != 5'd0)) begin
            pend_d[rd_addr_q] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            pend_q     <= '0;
            pc_q       <= '0;
            uop_q      <= '0;
            rd_write_q <= 1'b0;
            rd_addr_q  <= '0;
            zero_q     <= 2'b11;
            byp_q      <= '0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pc_q       <= pc_d;
            uop_q      <= uop_d;
            rd_write_q <= rd_write_d;
            rd_addr_q  <= rd_addr_d;
            zero_q     <= zero_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule

// File: tb/tb_armleocpu_operand_fetch.sv
// Directed, table-driven bench for armleocpu_operand_fetch with a small
// synchronous-read register file model attached to the read ports.
module tb_armleocpu_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [15:0] in_uop;
    logic        in_rs1_use, in_rs2_use;
    logic [4:0]  in_rs1_addr, in_rs2_addr;
    logic        in_rd_write;
    logic [4:0]  in_rd_addr;
    logic        rs1_read, rs2_read;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [15:0] out_uop;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic        out_rd_write;
    logic [4:0]  out_rd_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    armleocpu_operand_fetch #(.PC_W(32), .UOP_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_uop(in_uop),
        .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rd_write(in_rd_write), .in_rd_addr(in_rd_addr),
        .rs1_read(rs1_read), .rs2_read(rs2_read),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_uop(out_uop),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd_write(out_rd_write), .out_rd_addr(out_rd_addr)
    );

    // Register file model: 1-cycle read with enable/hold, read returns pre-write data.
    logic [31:0] regs [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'(32'h1000 + i);
            regs[5]   <= 32'h11;
            regs[6]   <= 32'h22;
            rs1_rdata <= '0;
            rs2_rdata <= '0;
        end else begin
            if (rs1_read) rs1_rdata <= regs[rs1_addr];
            if (rs2_read) rs2_rdata <= regs[rs2_addr];
            if (wb_write) regs[wb_addr] <= wb_wdata;
        end
    end

    typedef struct {
        logic        v;
        logic        u1;
        logic [4:0]  a1;
        logic        u2;
        logic [4:0]  a2;
        logic        rw;
        logic [4:0]  rd;
        logic        ordy;
        logic        wbw;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        fl;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic v, input logic u1, input logic [4:0] a1,
                       input logic u2, input logic [4:0] a2,
                       input logic rw, input logic [4:0] rd, input logic ordy,
                       input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic fl, input logic e_rdy, input logic e_ov,
                       input logic [31:0] e_r1, input logic [31:0] e_r2);
        vec_t t;
        t.v = v; t.u1 = u1; t.a1 = a1; t.u2 = u2; t.a2 = a2;
        t.rw = rw; t.rd = rd; t.ordy = ordy;
        t.wbw = wbw; t.wba = wba; t.wbd = wbd; t.fl = fl;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_r1 = e_r1; t.e_r2 = e_r2;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_pc = '0; in_uop = '0;
        in_rs1_use = 0; in_rs2_use = 0; in_rs1_addr = '0; in_rs2_addr = '0;
        in_rd_write = 0; in_rd_addr = '0;
        wb_write = 0; wb_addr = '0; wb_wdata = '0;
        flush = 0; out_ready = 1;
    endtask

    int exp_pc;

    initial begin
        rst_n = 0;
        idle_inputs();

        // Stimulus table: one row per cycle.
        //   v u1 a1 u2 a2 rw rd ordy wbw wba wbd       fl  rdy ov r1        r2
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 0 idle
        add(1, 1, 5, 1, 6, 0, 0, 1, 0, 0, 0,        0,  1, 1, 'h11,     'h22);    // 1 basic read
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 2 drain
        add(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0,        0,  1, 1, 0,        0);       // 3 A rd=3
        add(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0,        0,  0, 0, 0,        0);       // 4 B stalls on held A
        add(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0,        0,  0, 0, 0,        0);       // 5 B stalls on pend[3]
        add(1, 1, 3, 0, 0, 0, 0, 1, 1, 3, 'hABCD,   0,  1, 1, 'hABCD,   0);       // 6 accept with bypass
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 7 drain
        add(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,        0,  1, 1, 0,        0);       // 8 A rd=7 held
        add(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,        0,  0, 1, 0,        0);       // 9 B blocked, A held
        add(1, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0,        0,  0, 0, 0,        0);       // 10 release A, B stalls
        add(1, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0,        0,  0, 0, 0,        0);       // 11 pend[7]
        add(1, 1, 7, 0, 0, 0, 0, 1, 1, 7, 'h7777,   0,  1, 1, 'h7777,   0);       // 12 wb 7 frees B
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 13 drain
        add(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0,        0,  1, 1, 0,        0);       // 14 rd=9
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 15 pend[9] set
        add(1, 0, 9, 1, 0, 0, 0, 1, 0, 0, 0,        0,  1, 1, 0,        0);       // 16 unused x9, x0 used
        add(1, 1, 0, 1, 6, 0, 0, 1, 0, 0, 0,        0,  1, 1, 0,        'h22);    // 17 back-to-back
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 18 drain
        add(1, 0, 0, 0, 0, 1,10, 0, 0, 0, 0,        0,  1, 1, 0,        0);       // 19 rd=10 held
        add(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0,        1,  0, 0, 0,        0);       // 20 flush
        add(1, 1,10, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 1, 'h100A,   0);       // 21 no pend[10]
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 22 drain
        add(1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0,        0,  0, 0, 0,        0);       // 23 pend[9] survived
        add(1, 1, 9, 0, 0, 0, 0, 1, 1, 9, 'h9999,   0,  1, 1, 'h9999,   0);       // 24 wb 9
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 25 drain
        add(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0,        0,  1, 1, 0,        0);       // 26 rd=4
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 27 pend[4] set
        add(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0,        0,  0, 0, 0,        0);       // 28 WAW stall
        add(1, 0, 0, 0, 0, 1, 4, 1, 1, 4, 'h4A4A,   0,  1, 1, 0,        0);       // 29 WAW freed by wb
        add(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 'h4040,   0,  1, 0, 0,        0);       // 30 set beats clear
        add(1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0,        0,  0, 0, 0,        0);       // 31 pend[4] again
        add(1, 1, 4, 0, 0, 0, 0, 1, 1, 4, 'h4444,   0,  1, 1, 'h4444,   0);       // 32 wb 4
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,        0,  1, 0, 0,        0);       // 33 drain

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_pc", out_pc, 0);
        chk("reset out_rs1_data", out_rs1_data, 0);
        chk("reset rs1_read", 32'(rs1_read), 0);
        @(negedge clk);
        rst_n = 1;

        exp_pc = 0;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            in_valid = vq[i].v; in_pc = 32'(i); in_uop = 16'(i);
            in_rs1_use = vq[i].u1; in_rs1_addr = vq[i].a1;
            in_rs2_use = vq[i].u2; in_rs2_addr = vq[i].a2;
            in_rd_write = vq[i].rw; in_rd_addr = vq[i].rd;
            out_ready = vq[i].ordy; flush = vq[i].fl;
            wb_write = vq[i].wbw; wb_addr = vq[i].wba; wb_wdata = vq[i].wbd;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_rdy));
            chk($sformatf("v%0d rs1_read", i), 32'(rs1_read), 32'(vq[i].v && vq[i].e_rdy && vq[i].u1));
            chk($sformatf("v%0d rs2_read", i), 32'(rs2_read), 32'(vq[i].v && vq[i].e_rdy && vq[i].u2));
            chk($sformatf("v%0d rs1_addr", i), 32'(rs1_addr), 32'(vq[i].a1));
            @(posedge clk);
            if (vq[i].v && vq[i].e_rdy) exp_pc = i;
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
            if (vq[i].e_ov) begin
                chk($sformatf("v%0d out_rs1_data", i), out_rs1_data, vq[i].e_r1);
                chk($sformatf("v%0d out_rs2_data", i), out_rs2_data, vq[i].e_r2);
                chk($sformatf("v%0d out_pc", i), out_pc, 32'(exp_pc));
                chk($sformatf("v%0d out_uop", i), 32'(out_uop), 32'(exp_pc));
            end
            $display("vec %0d: in_ready=%0d out_valid=%0d rs1=%h rs2=%h",
                     i, in_ready, out_valid, out_rs1_data, out_rs2_data);
        end

        // Hold stability and asynchronous reset while HELD with a pending bit.
        @(negedge clk);
        idle_inputs();
        in_valid = 1; in_pc = 32'h200; in_rd_write = 1; in_rd_addr = 5'd12;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        in_valid = 1; in_pc = 32'h204;
        in_rs1_use = 1; in_rs1_addr = 5'd5; in_rs2_use = 1; in_rs2_addr = 5'd6;
        #1;
        chk("b2b in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        out_ready = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d out_valid", k), 32'(out_valid), 1);
            chk($sformatf("hold%0d out_rs1_data", k), out_rs1_data, 32'h11);
            chk($sformatf("hold%0d out_rs2_data", k), out_rs2_data, 32'h22);
            chk($sformatf("hold%0d out_pc", k), out_pc, 32'h204);
            $display("hold %0d: out_valid=%0d rs1=%h rs2=%h", k, out_valid, out_rs1_data, out_rs2_data);
        end
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 0);
        chk("async rst out_rs1_data", out_rs1_data, 0);
        chk("async rst out_pc", out_pc, 0);
        $display("async reset: out_valid=%0d out_pc=%h", out_valid, out_pc);
        #1;
        rst_n = 1;
        @(negedge clk);
        idle_inputs();
        in_rs1_use = 1; in_rs1_addr = 5'd12;
        #1;
        chk("post-reset pend[12] clear", 32'(in_ready), 1);
        chk("post-reset rs1_read", 32'(rs1_read), 0);
        $display("post reset: in_ready=%0d", in_ready);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
